sseg_scan_capture: RTL and testbench
====================================

Name: sseg_scan_capture

Overview:
- Receive-side counterpart of the board's seven-segment driver. It watches the multiplexed, active-low anode, segment and dp lines that a display driver produces.
- Filters out scan and glitch transients, then decodes each segment pattern back to a digit value. It holds a per-digit value register for each of the 4 digit positions.
- Used for loopback self-test of display drivers and for on-chip readback of displayed values.

Parameters:
- STABLE_CYCLES, 16: consecutive clk cycles the synchronised {an,seg,dp} bundle must be unchanged before it is accepted; legal range 1..65535.
- STALE_CYCLES, 100000000: cycles without a refresh of a digit before its valid bit clears; 0 disables staleness. Counter width is $clog2(STALE_CYCLES+1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- an  in  [0:3]  anode enables, active-low; an[0] low selects digit 0
- seg  in  [0:6]  segments a..g, active-low; seg[0]=a, seg[6]=g
- dp  in  1  decimal point line, captured as-is
- digits  out  16  decoded values; digit i at [4i+3:4i]
- digit_valid  out  4  digit i holds a fresh, legal decode
- dp_cap  out  4  dp level captured with digit i
- update  out  1  one-cycle pulse when a committed digit value or valid bit changes
- update_idx  out  2  index of the digit for the current update; held between pulses
- bad_pattern  out  1  one-cycle pulse on commit of an illegal frame

Behaviour:
- Reset (async assert, synchronous release through the clock domain): digits=0, digit_valid=0, dp_cap=0, update=0, update_idx=0, bad_pattern=0. Synchroniser flops are set to all-ones (blank) and the FSM goes to SETTLE with count 0.
- Input path: an, seg and dp pass through a 2-flop synchroniser. The stage-2 bundle S is the filtered sample.
- FSM:
  - SETTLE: count increments each cycle that S equals its previous-cycle value. Any difference resets count to 0. When count reaches STABLE_CYCLES-1 with S still equal, the frame is committed and the FSM goes to LOCKED.
  - LOCKED: no further commits. Any change in S returns the FSM to SETTLE with count=0.
- Commit decode:
  - an all ones (blank): no capture, no pulse.
  - Exactly one an bit low → index i. The seg pattern is decoded: 0=7'h01, 1=7'h4F, 2=7'h12, 3=7'h06, 4=7'h4C, 5=7'h24, 6=7'h20, 7=7'h0F, 8=7'h00, 9=7'h04.
  - Legal pattern: digits[i] gets the value, digit_valid[i]=1, dp_cap[i]=dp, and the stale counter for i clears.
  - update pulses with update_idx=i only if the value, valid or dp_cap actually changed.
  - Illegal pattern, or more than one an low: bad_pattern pulses; if exactly one an is low, digit_valid[i]=0 and digits[i] is retained.
- Latency: an input change held steady reaches the update pulse exactly STABLE_CYCLES+3 clk edges after it is sampled.
- Staleness: each digit has a saturating counter that increments every cycle. On reaching STALE_CYCLES, digit_valid[i] clears and update pulses with update_idx=i. Saturation holds until the next commit.
- Simultaneous events:
  - A commit and a stale expiry on different digits in the same cycle: the commit wins the update pulse. The expiry is deferred one cycle; the counter stays saturated and is retried.
  - A commit and a stale expiry on the same digit: the commit wins and the counter clears.
- Reset mid-settle discards the pending frame.

Optional Feature:
- Macro: SSEG_SCAN_HEX_DECODE_EN.
- Defined: additionally decodes A=7'h08, b=7'h60, C=7'h31, d=7'h42, E=7'h30, F=7'h38 to values 10..15 as legal.
- Undefined: those patterns are illegal and raise bad_pattern.

Test Plan:
- Bench uses STABLE_CYCLES=4, STALE_CYCLES=50.
- Reset: assert rst_n=0 mid-run → all outputs 0 immediately, with no clk edge required.
- Static digit: an=4'b0111, seg=7'h06, dp=0 → update pulses exactly 7 cycles later with update_idx=0. Result: digits[3:0]=3, digit_valid=4'b0001, dp_cap[0]=0. No second pulse while the inputs are held.
- Glitch rejection: an=4'b1011, seg=7'h24 with a 2-cycle glitch to 7'h00 inserted every 3 cycles → no commit. After the glitches stop: digits[7:4]=5 with one update pulse.
- Scan of 4 digits, each held 10 cycles with patterns 1, 2, 8, 9 → digits=16'h9821, digit_valid=4'hF, four update pulses with indices 0..3.
- Illegal frames: seg=7'h7F with an=4'b0111 → bad_pattern pulse and digit_valid[0]=0. an=4'b0011 → bad_pattern pulse with no digit changed.
- Stale and hex:
  - Commit digit 2, then blank → 50 cycles later digit_valid[2]=0 with an update pulse, idx=2.
  - With the macro defined, seg=7'h08 → value 4'hA.
  - With the macro undefined, seg=7'h08 → bad_pattern.

Source files
------------

// File: rtl/sseg_scan_capture.sv
// sseg_scan_capture: seven-segment scan receiver; synchronises and settles the
// multiplexed an/seg/dp lines, decodes each stable frame into per-digit
// registers, and ages digits out when they are not refreshed.
// Optional: define SSEG_SCAN_HEX_DECODE_EN to accept A..F glyphs as 10..15.
module sseg_scan_capture #(
   parameter int STABLE_CYCLES = 16,
   parameter int STALE_CYCLES  = 100000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [0:3]  an,
   input  logic [0:6]  seg,
   input  logic        dp,
   output logic [15:0] digits,
   output logic [3:0]  digit_valid,
   output logic [3:0]  dp_cap,
   output logic        update,
   output logic [1:0]  update_idx,
   output logic        bad_pattern
);

   localparam int CW = 16;
   localparam int SW = (STALE_CYCLES > 0) ? $clog2(STALE_CYCLES + 1) : 1;
   localparam bit STALE_EN = (STALE_CYCLES > 0);
   localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CYCLES - 1);
   localparam logic [SW-1:0] STALE_MAX = SW'(STALE_CYCLES);
   localparam logic [SW-1:0] STALE_PRE = SW'((STALE_CYCLES > 0) ? STALE_CYCLES - 1 : 0);
   localparam logic [0:0] ST_SETTLE = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   // Returns {legal, value}; segment order is a..g from MSB to LSB, active-low.
   function automatic logic [4:0] f_decode(input logic [6:0] p);
      logic [4:0] r;
      case (p)
         7'h01:   r = {1'b1, 4'd0};
         7'h4F:   r = {1'b1, 4'd1};
         7'h12:   r = {1'b1, 4'd2};
         7'h06:   r = {1'b1, 4'd3};
         7'h4C:   r = {1'b1, 4'd4};
         7'h24:   r = {1'b1, 4'd5};
         7'h20:   r = {1'b1, 4'd6};
         7'h0F:   r = {1'b1, 4'd7};
         7'h00:   r = {1'b1, 4'd8};
         7'h04:   r = {1'b1, 4'd9};
`ifdef SSEG_SCAN_HEX_DECODE_EN
         7'h08:   r = {1'b1, 4'd10};
         7'h60:   r = {1'b1, 4'd11};
         7'h31:   r = {1'b1, 4'd12};
         7'h42:   r = {1'b1, 4'd13};
         7'h30:   r = {1'b1, 4'd14};
         7'h38:   r = {1'b1, 4'd15};
`endif
         default: r = 5'd0;
      endcase
      return r;
   endfunction

   logic [0:3]    r_an1, r_an2, r_an_p;
   logic [0:6]    r_seg1, r_seg2, r_seg_p;
   logic          r_dp1, r_dp2, r_dp_p;
   logic [0:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_dig [4];
   logic [3:0]    r_valid, r_dpc;
   logic [SW-1:0] r_scnt [4];
   logic          r_upd, r_bad;
   logic [1:0]    r_upd_idx;

   logic [0:3]    w_low;
   logic          w_same, w_commit, w_blank, w_one, w_cap;
   logic [1:0]    w_idx;
   logic [4:0]    w_dec;
   logic          w_legal;
   logic [3:0]    w_val;
   logic          w_chg, w_cupd, w_bad;
   logic [3:0]    w_exp;
   logic          w_sv;
   logic [1:0]    w_sv_idx;

   // Two-flop synchroniser; idles at all-ones so reset looks like a blank display.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_an1  <= '1;
         r_an2  <= '1;
         r_seg1 <= '1;
         r_seg2 <= '1;
         r_dp1  <= 1'b1;
         r_dp2  <= 1'b1;
      end else begin
         r_an1  <= an;
         r_an2  <= r_an1;
         r_seg1 <= seg;
         r_seg2 <= r_seg1;
         r_dp1  <= dp;
         r_dp2  <= r_dp1;
      end
   end

   assign w_same   = ({r_an2, r_seg2, r_dp2} == {r_an_p, r_seg_p, r_dp_p});
   assign w_commit = (r_state == ST_SETTLE) && w_same && (r_cnt == CNT_LAST);

   // Settle filter: a frame commits once after being unchanged long enough.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_SETTLE;
         r_cnt   <= '0;
         r_an_p  <= '1;
         r_seg_p <= '1;
         r_dp_p  <= 1'b1;
      end else begin
         r_an_p  <= r_an2;
         r_seg_p <= r_seg2;
         r_dp_p  <= r_dp2;
         if (!w_same) begin
            r_state <= ST_SETTLE;
            r_cnt   <= '0;
         end else if (r_state == ST_SETTLE) begin
            if (r_cnt == CNT_LAST)
               r_state <= ST_LOCKED;
            else
               r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign w_low   = ~r_an2;
   assign w_blank = (w_low == 4'b0000);
   assign w_one   = !w_blank && ((w_low & (w_low - 1'b1)) == 4'b0000);
   assign w_cap   = w_commit && w_one;
   assign w_dec   = f_decode(r_seg2);
   assign w_legal = w_dec[4];
   assign w_val   = w_dec[3:0];

   // Digit index of the single active anode.
   always_comb begin
      w_idx = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (w_low[i]) w_idx = 2'(i);
   end

   assign w_chg  = (r_dig[w_idx] != w_val) || !r_valid[w_idx] || (r_dpc[w_idx] != r_dp2);
   assign w_cupd = w_cap && (w_legal ? w_chg : r_valid[w_idx]);
   assign w_bad  = w_commit && !w_blank && (!w_one || !w_legal);

   // Expiry candidates; a digit being committed this cycle is never expired.
   always_comb begin
      w_exp = 4'b0000;
      for (int i = 0; i < 4; i++)
         w_exp[i] = STALE_EN && r_valid[i] && (r_scnt[i] >= STALE_PRE) && !(w_cap && (w_idx == 2'(i)));
   end

   // Commit owns the update pulse; an expiry waits and retries while saturated.
   always_comb begin
      w_sv_idx = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (w_exp[i]) w_sv_idx = 2'(i);
   end

   assign w_sv = !w_cupd && (w_exp != 4'b0000);

   // Per-digit refresh age, cleared by a legal commit and saturating at the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++)
            r_scnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++)
            if (w_cap && w_legal && (w_idx == 2'(i)))
               r_scnt[i] <= '0;
            else if (r_scnt[i] != STALE_MAX)
               r_scnt[i] <= r_scnt[i] + 1'b1;
      end
   end

   // Digit value, valid and dp registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++)
            r_dig[i] <= 4'd0;
         r_valid <= 4'b0000;
         r_dpc   <= 4'b0000;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (w_cap && (w_idx == 2'(i))) begin
               if (w_legal) begin
                  r_dig[i]   <= w_val;
                  r_valid[i] <= 1'b1;
                  r_dpc[i]   <= r_dp2;
               end else begin
                  r_valid[i] <= 1'b0;
               end
            end else if (w_sv && (w_sv_idx == 2'(i))) begin
               r_valid[i] <= 1'b0;
            end
         end
      end
   end

   // Event pulses; update_idx holds its last value between pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_upd     <= 1'b0;
         r_upd_idx <= 2'd0;
         r_bad     <= 1'b0;
      end else begin
         r_upd     <= w_cupd || w_sv;
         r_upd_idx <= w_cupd ? w_idx : (w_sv ? w_sv_idx : r_upd_idx);
         r_bad     <= w_bad;
      end
   end

   assign digits      = {r_dig[3], r_dig[2], r_dig[1], r_dig[0]};
   assign digit_valid = r_valid;
   assign dp_cap      = r_dpc;
   assign update      = r_upd;
   assign update_idx  = r_upd_idx;
   assign bad_pattern = r_bad;

endmodule

// File: tb/tb_sseg_scan_capture.sv
// tb_sseg_scan_capture: directed bench for sseg_scan_capture (STABLE=4, STALE=50).
module tb_sseg_scan_capture;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [0:3]  an = '1;
   logic [0:6]  seg = '1;
   logic        dp = 1'b1;
   logic [15:0] digits;
   logic [3:0]  digit_valid;
   logic [3:0]  dp_cap;
   logic        update;
   logic [1:0]  update_idx;
   logic        bad_pattern;

   int checks = 0;
   int failures = 0;
   int n_upd = 0;
   int n_bad = 0;
   logic [1:0] idx_q [$];

   sseg_scan_capture #(.STABLE_CYCLES(4), .STALE_CYCLES(50)) dut (
      .clk(clk), .rst_n(rst_n), .an(an), .seg(seg), .dp(dp),
      .digits(digits), .digit_valid(digit_valid), .dp_cap(dp_cap),
      .update(update), .update_idx(update_idx), .bad_pattern(bad_pattern)
   );

   always #5 clk = ~clk;

   // Pulse counters, read just before each edge updates the outputs.
   always @(posedge clk) begin
      if (update) begin
         n_upd++;
         idx_q.push_back(update_idx);
      end
      if (bad_pattern) n_bad++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d);
      an  = a;
      seg = s;
      dp  = d;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      drive(4'b1111, 7'h7F, 1'b1);
      rst_n = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(10);
   endtask

   initial begin
      int base, bbase, qb, hit;
      logic [1:0] hidx;
      logic [6:0] pat [4];
      pat[0] = 7'h4F; pat[1] = 7'h12; pat[2] = 7'h00; pat[3] = 7'h04;

      do_reset();
      chk("rst_digits", digits, 0);
      chk("rst_valid", digit_valid, 0);
      chk("rst_dpcap", dp_cap, 0);
      chk("rst_idx", update_idx, 0);
      chk("rst_bad", bad_pattern, 0);
      chk("rst_no_upd", n_upd, 0);

      base = n_upd;
      drive(4'b0111, 7'h06, 1'b0);
      cyc(6);
      chk("lat_early", update, 0);
      cyc(1);
      chk("lat_pulse", update, 1);
      chk("lat_idx", update_idx, 0);
      chk("st_digit", digits[3:0], 3);
      chk("st_valid", digit_valid, 4'b0001);
      chk("st_dp", dp_cap[0], 0);
      cyc(20);
      chk("st_once", n_upd - base, 1);
      drive(4'b0111, 7'h06, 1'b1);
      cyc(10);
      chk("dp_cap", dp_cap, 4'b0001);
      chk("dp_upd", n_upd - base, 2);

      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async_rst", {digits, digit_valid, dp_cap, update, update_idx, bad_pattern}, 0);
      do_reset();

      base = n_upd;
      repeat (8) begin
         drive(4'b1011, 7'h24, 1'b0);
         cyc(1);
         drive(4'b1011, 7'h00, 1'b0);
         cyc(2);
      end
      chk("glitch_none", n_upd - base, 0);
      chk("glitch_valid", digit_valid, 0);
      drive(4'b1011, 7'h24, 1'b0);
      cyc(12);
      chk("glitch_digit", digits[7:4], 5);
      chk("glitch_upd", n_upd - base, 1);
      chk("glitch_idx", update_idx, 1);
      do_reset();

      base = n_upd;
      qb = idx_q.size();
      for (int d = 0; d < 4; d++) begin
         drive(~(4'b1000 >> d), pat[d], 1'b0);
         cyc(10);
      end
      drive(4'b1111, 7'h7F, 1'b1);
      cyc(3);
      chk("scan_digits", digits, 16'h9821);
      chk("scan_valid", digit_valid, 4'hF);
      chk("scan_upd", n_upd - base, 4);
      for (int d = 0; d < 4; d++)
         if (qb + d < idx_q.size()) chk("scan_idx", idx_q[qb + d], d);
      do_reset();

      drive(4'b0111, 7'h06, 1'b0);
      cyc(10);
      bbase = n_bad;
      drive(4'b0111, 7'h7F, 1'b0);
      cyc(10);
      chk("ill_bad", n_bad - bbase, 1);
      chk("ill_valid", digit_valid[0], 0);
      chk("ill_keep", digits[3:0], 3);
      base = n_upd;
      drive(4'b0011, 7'h06, 1'b0);
      cyc(10);
      chk("multi_bad", n_bad - bbase, 2);
      chk("multi_digits", digits, 16'h0003);
      chk("multi_valid", digit_valid, 0);
      chk("multi_no_upd", n_upd - base, 0);
      do_reset();

      drive(4'b1101, 7'h12, 1'b0);
      cyc(7);
      chk("stale_commit", update, 1);
      chk("stale_valid1", digit_valid, 4'b0100);
      chk("stale_digit", digits[11:8], 2);
      drive(4'b1111, 7'h7F, 1'b1);
      hit = 0;
      hidx = 2'd0;
      for (int j = 1; j <= 60; j++) begin
         @(negedge clk);
         if (update && hit == 0) begin
            hit = j;
            hidx = update_idx;
         end
      end
      chk("stale_at", hit, 50);
      chk("stale_idx", hidx, 2);
      chk("stale_valid0", digit_valid, 0);
      do_reset();

      bbase = n_bad;
      drive(4'b0111, 7'h08, 1'b0);
      cyc(10);
`ifdef SSEG_SCAN_HEX_DECODE_EN
      chk("hex_digit", digits[3:0], 4'hA);
      chk("hex_valid", digit_valid, 4'b0001);
      chk("hex_no_bad", n_bad - bbase, 0);
`else
      chk("hex_bad", n_bad - bbase, 1);
      chk("hex_valid", digit_valid, 0);
      chk("hex_digit", digits[3:0], 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
